// File: rtl/gray_sweep_eval.sv
// Walks a Gray-coded input sweep through a loadable truth table; first step one cycle after start.
// hold freezes the sweep in place; table loads and start requests are taken only while idle.
module gray_sweep_eval #(
  parameter int               N       = 3,
  parameter logic [2**N-1:0]  TT_INIT = 8'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic              tt_we,
  input  logic [2**N-1:0]   tt_in,
  output logic [N-1:0]      vec,
  output logic              s,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [N:0]        ones_cnt
);

  localparam logic [N-1:0] K_LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      k_q, k_d;
  logic [N-1:0]      vec_q, vec_d;
  logic              s_q, s_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N:0]        ones_q, ones_d;
  logic [2**N-1:0]   tt_q, tt_d;
  logic              last_q, last_d;
  logic [N-1:0]      gray_k;
  logic              tt_bit;

  assign gray_k = k_q ^ (k_q >> 1);
  assign tt_bit = tt_q[gray_k];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vec_d   = vec_q;
    s_d     = s_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    tt_d    = tt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (tt_we) begin
          tt_d = tt_in;
        end
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end

      RUN: begin
        // last_q marks that the final step is already on the outputs; k has wrapped and must not emit again
        if (last_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = 1'b0;
        end else if (!hold) begin
          vec_d   = gray_k;
          s_d     = tt_bit;
          ones_d  = ones_q + {{N{1'b0}}, tt_bit};
          valid_d = 1'b1;
          k_d     = k_q + N'(1);
          last_d  = (k_q == K_LAST);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      vec_q   <= '0;
      s_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      tt_q    <= TT_INIT;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      tt_q    <= tt_d;
      last_q  <= last_d;
    end
  end

  assign vec      = vec_q;
  assign s        = s_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_gray_sweep_eval.sv
// Directed bench for gray_sweep_eval: default N=3 instance plus an N=1 instance.
module tb_gray_sweep_eval;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       tt_we = 1'b0;
  logic [7:0] tt_in = 8'h00;
  logic [2:0] vec;
  logic       s, valid, busy, done;
  logic [3:0] ones_cnt;

  logic       start1 = 1'b0;
  logic       hold1 = 1'b0;
  logic       tt_we1 = 1'b0;
  logic [1:0] tt_in1 = 2'b00;
  logic [0:0] vec1;
  logic       s1, valid1, busy1, done1;
  logic [1:0] ones1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] exp_vec [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic       exp_s   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  gray_sweep_eval #(.N(3), .TT_INIT(8'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .tt_we(tt_we), .tt_in(tt_in),
    .vec(vec), .s(s), .valid(valid), .busy(busy), .done(done), .ones_cnt(ones_cnt)
  );

  gray_sweep_eval #(.N(1), .TT_INIT(2'b10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1), .tt_we(tt_we1), .tt_in(tt_in1),
    .vec(vec1), .s(s1), .valid(valid1), .busy(busy1), .done(done1), .ones_cnt(ones1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    tests_run++;
    if ({vec, s, valid, busy, done, ones_cnt} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected all zero", {vec, s, valid, busy, done, ones_cnt});
    end
    tests_run++;
    if ({vec1, s1, valid1, busy1, done1, ones1} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_n1: got %b expected all zero", {vec1, s1, valid1, busy1, done1, ones1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_basic_sweep;
    int edge_n;
    int done_edge;
    int done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    edge_n = 1;
    tests_run++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_first_cycle: busy=%b valid=%b expected 1 0", busy, valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      edge_n++;
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL basic_step[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_s[i]);
      end
    end
    done_edge = 0;
    done_count = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      edge_n++;
      if (done === 1'b1) begin
        done_count++;
        if (done_edge == 0) done_edge = edge_n;
      end
    end
    tests_run++;
    if (done_edge != 10) begin
      tests_failed++;
      $display("FAIL basic_done_edge: got %0d expected 10", done_edge);
    end
    tests_run++;
    if (done_count != 1) begin
      tests_failed++;
      $display("FAIL basic_done_width: got %0d expected 1", done_count);
    end
    tests_run++;
    if (ones_cnt !== 4'd6 || vec !== 3'd4 || s !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_final: ones=%0d vec=%0d s=%b busy=%b expected 6 4 1 0", ones_cnt, vec, s, busy);
    end
  endtask

  task automatic test_table_load;
    tt_we = 1'b1;
    tt_in = 8'h01;
    tick();
    tt_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== (exp_vec[i] == 3'd0)) begin
        tests_failed++;
        $display("FAIL load_step[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_vec[i] == 3'd0);
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL load_done: done=%b ones=%0d expected 1 1", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_load_with_start;
    tt_we = 1'b1;
    tt_in = 8'h80;
    start = 1'b1;
    tick();
    tt_we = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== (exp_vec[i] == 3'd7)) begin
        tests_failed++;
        $display("FAIL loadstart_step[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_vec[i] == 3'd7);
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL loadstart_done: done=%b ones=%0d expected 1 1", done, ones_cnt);
    end
    tick();
    tt_we = 1'b1;
    tt_in = 8'h3F;
    tick();
    tt_we = 1'b0;
  endtask

  task automatic test_hold;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL hold_pre[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_s[i]);
      end
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      tests_run++;
      if (valid !== 1'b0 || vec !== 3'd3 || ones_cnt !== 4'd3 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_frozen[%0d]: valid=%b vec=%0d ones=%0d busy=%b expected 0 3 3 1", h, valid, vec, ones_cnt, busy);
      end
    end
    hold = 1'b0;
    for (int i = 3; i < 8; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL hold_post[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_s[i]);
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL hold_done: done=%b ones=%0d expected 1 6", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_ignore_in_run;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b1;
        tt_we = 1'b1;
        tt_in = 8'hFF;
      end
      tests_run++;
      if (valid !== 1'b1 || vec !== exp_vec[i] || s !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL ignore_step[%0d]: valid=%b vec=%0d s=%b expected 1 %0d %b", i, valid, vec, s, exp_vec[i], exp_s[i]);
      end
    end
    start = 1'b0;
    tt_we = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL ignore_done: done=%b ones=%0d expected 1 6", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b expected 1", done);
    end
    start = 1'b1;
    tt_we = 1'b1;
    tt_in = 8'hFF;
    tick();
    tt_we = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start_in_done: busy=%b done=%b valid=%b expected 0 0 0", busy, done, valid);
    end
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || ones_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_restart: busy=%b ones=%0d expected 1 0", busy, ones_cnt);
    end
    for (int i = 0; i < 9; i++) tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL b2b_table_kept: done=%b ones=%0d expected 1 6", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    int seen;
    tt_we = 1'b1;
    tt_in = 8'h01;
    tick();
    tt_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (vec !== 3'd6 || valid !== 1'b1 || ones_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: vec=%0d valid=%b ones=%0d expected 6 1 1", vec, valid, ones_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vec, s, valid, busy, done, ones_cnt} !== 10'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %b expected all zero", {vec, s, valid, busy, done, ones_cnt});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    tests_run++;
    if (done !== 1'b1 || ones_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL rstmid_table_restored: done=%b ones=%0d expected 1 6", done, ones_cnt);
    end
    tick();
  endtask

  task automatic test_n1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tests_run++;
    if (valid1 !== 1'b1 || vec1 !== 1'b0 || s1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL n1_step0: valid=%b vec=%0d s=%b done=%b expected 1 0 0 0", valid1, vec1, s1, done1);
    end
    tick();
    tests_run++;
    if (valid1 !== 1'b1 || vec1 !== 1'b1 || s1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL n1_step1: valid=%b vec=%0d s=%b done=%b expected 1 1 1 0", valid1, vec1, s1, done1);
    end
    tick();
    tests_run++;
    if (done1 !== 1'b1 || valid1 !== 1'b0 || ones1 !== 2'd1 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL n1_done: done=%b valid=%b ones=%0d busy=%b expected 1 0 1 0", done1, valid1, ones1, busy1);
    end
    tick();
    tests_run++;
    if (done1 !== 1'b0 || vec1 !== 1'b1 || ones1 !== 2'd1) begin
      tests_failed++;
      $display("FAIL n1_idle: done=%b vec=%0d ones=%0d expected 0 1 1", done1, vec1, ones1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_table_load();
    test_load_with_start();
    test_hold();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_sweep();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gray_sweep_eval.md
GRAY_SWEEP_EVAL -- requirements
Module: gray_sweep_eval

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the input-vector width (legal range 1..6).
REQ-002 The block SHALL have parameter TT_INIT, width 2^N, default 8'h3F, meaning the truth table loaded at reset; bit i is the output for vector value i. The default encodes s = !(a&c) | !(b|c) with vector {a,c,b}, a as MSB.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- clk      input   1       clock; all state changes on rising edge
- rst_n    input   1       asynchronous active-low reset
- start    input   1       request one full sweep
- hold     input   1       pause sweep, active high
- tt_we    input   1       load tt_in into truth-table register
- tt_in    input   2^N     new truth table
- vec      output  N       current Gray-coded input vector
- s        output  1       truth-table value for vec
- valid    output  1       vec/s pair is a new sweep step this cycle
- busy     output  1       sweep in progress
- done     output  1       one-cycle pulse after final step
- ones_cnt output  N+1     number of steps with s=1 in last or current sweep

Function
REQ-004 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 The block SHALL keep an internal step counter k, N bits wide. The sweep vector SHALL be gray(k) = k ^ (k>>1).
REQ-006 IDLE with start=1 SHALL go to RUN on the next edge and, on that same edge, set k=0, clear ones_cnt and assert busy.
REQ-007 Each RUN cycle with hold=0 SHALL, on the edge, register vec=gray(k) and s=table[gray(k)], add s to ones_cnt, assert valid and increment k.
REQ-008 vec and s SHALL always be mutually consistent in the same cycle, so there is no extra latency between them. The first valid step SHALL appear one cycle after start is sampled.
REQ-009 A RUN cycle with hold=1 SHALL leave k, vec, s and ones_cnt unchanged and drive valid=0 on the following cycle. Sweep order is unaffected by any pattern of hold.
REQ-010 After the step with k=2^N-1 is emitted, the next edge SHALL enter DONE. In DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE on the following edge.
REQ-011 A sweep SHALL emit exactly 2^N valid steps, each Gray value exactly once. Consecutive valid vec values SHALL differ in exactly one bit.
REQ-012 k wrap-around from 2^N-1 SHALL never produce a step. k only rolls to 0 in hardware and is reloaded on the next start.
REQ-013 start SHALL be ignored in RUN and DONE. In DONE, start=1 is also ignored, so there is no back-to-back restart without one IDLE cycle.
REQ-014 tt_we SHALL be honoured only in IDLE: the table register takes tt_in on the edge. In RUN or DONE, tt_we SHALL be ignored so the table is frozen for the whole sweep.
REQ-015 If tt_we and start are both 1 in IDLE, the table SHALL load and the sweep SHALL use the new table from its first step.
REQ-016 In IDLE and DONE, vec and s SHALL hold the last emitted values, and ones_cnt SHALL hold its final count until the next start.
REQ-017 ones_cnt SHALL count up to 2^N without overflow, given its N+1 width.

Reset
REQ-018 Assertion of rst_n=0 SHALL immediately, without a clock, force: state=IDLE, k=0, vec=0, s=0, valid=0, busy=0, done=0, ones_cnt=0, table=TT_INIT.
REQ-019 Reset mid-sweep SHALL abort the sweep with no done pulse. The first edge after deassertion SHALL behave as IDLE.

Verification
REQ-020 Default N=3, TT_INIT=8'h3F, start pulse: the bench SHALL check that vec sequence 0,1,3,2,6,7,5,4 gives s sequence 1,1,1,1,0,0,1,1 on 8 consecutive valid cycles, done on cycle 10 after start, and ones_cnt=6.
REQ-021 In IDLE, tt_we=1 with tt_in=8'h01, then start: the bench SHALL check s=1 only at vec=0 and ones_cnt=1.
REQ-022 With hold=1 for 3 cycles after the third valid step: the bench SHALL check vec stays 3, valid=0 for 3 cycles, the sweep resumes at vec=2 and completes with ones_cnt=6.
REQ-023 With start and tt_we=1 (tt_in=8'hFF) asserted during RUN: the bench SHALL check both are ignored, the sweep is unchanged and ones_cnt=6.
REQ-024 With rst_n=0 asserted mid-edge after vec=6: the bench SHALL check all outputs zero immediately, no done pulse, and table restored so that the next sweep gives ones_cnt=6.
REQ-025 With N=1 and TT_INIT=2'b10: the bench SHALL check vec 0,1, s 0,1, ones_cnt=1, done two cycles after the last valid step's predecessor.
